// File: rtl/pixel_feeder.sv
// Credit-based pixel feeder: streams upstream pixels line by line into downstream
// line buffers, stalls when no buffer is free, and appends zero pad lines per frame.
module pixel_feeder #(
    parameter int LINE_WIDTH  = 512,
    parameter int NUM_LINES   = 512,
    parameter int NUM_BUFFERS = 4,
    parameter int PAD_LINES   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    output logic [7:0] o_pixel_data,
    output logic       o_pixel_data_valid,
    input  logic       i_intr,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int PW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LMAX = (NUM_LINES > PAD_LINES) ? NUM_LINES : PAD_LINES;
    localparam int LW   = $clog2(LMAX + 1);
    localparam int CW   = $clog2(NUM_BUFFERS + 1);

    localparam logic [PW-1:0] PIX_LAST   = PW'(LINE_WIDTH - 1);
    localparam logic [LW-1:0] LINES_ALL  = LW'(NUM_LINES);
    localparam logic [LW-1:0] PADS_ALL   = LW'(PAD_LINES);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(NUM_BUFFERS);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_CREDIT,
        PAD,
        PAD_WAIT,
        DONE
    } state_t;

    state_t          state, state_nxt, after_data;
    logic [PW-1:0]   pix_cnt;
    logic [LW-1:0]   line_cnt, line_cnt_inc;
    logic [CW-1:0]   credits, credits_nxt;
    logic            xfer, pad_emit, line_end, err_set;

    assign o_s_ready = (state == SEND);
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

    always_comb begin
        xfer         = (state == SEND) && i_s_valid;
        pad_emit     = (state == PAD);
        line_end     = (xfer || pad_emit) && (pix_cnt == PIX_LAST);
        line_cnt_inc = line_cnt + 1'b1;
        after_data   = (PAD_LINES == 0) ? DONE : PAD;

        // A freed buffer and a consumed buffer in the same cycle cancel out.
        credits_nxt = credits;
        err_set     = 1'b0;
        if (i_intr && !line_end) begin
            if (credits == CREDIT_MAX)
                err_set = 1'b1;
            else
                credits_nxt = credits + 1'b1;
        end else if (!i_intr && line_end) begin
            credits_nxt = credits - 1'b1;
        end

        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start)
                    state_nxt = SEND;
            end
            SEND: begin
                if (line_end) begin
                    if (credits_nxt == '0)
                        state_nxt = WAIT_CREDIT;
                    else if (line_cnt_inc == LINES_ALL)
                        state_nxt = after_data;
                end
            end
            WAIT_CREDIT: begin
                if (credits != '0)
                    state_nxt = (line_cnt == LINES_ALL) ? after_data : SEND;
            end
            PAD: begin
                if (line_end) begin
                    if (credits_nxt == '0)
                        state_nxt = PAD_WAIT;
                    else if (line_cnt_inc == PADS_ALL)
                        state_nxt = DONE;
                end
            end
            PAD_WAIT: begin
                if (credits != '0)
                    state_nxt = (line_cnt == PADS_ALL) ? DONE : PAD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            pix_cnt            <= '0;
            line_cnt           <= '0;
            credits            <= CREDIT_MAX;
            o_err              <= 1'b0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
        end else begin
            state              <= state_nxt;
            credits            <= credits_nxt;
            o_pixel_data_valid <= xfer || pad_emit;
            o_pixel_data       <= xfer ? i_s_data : '0;
            if (err_set)
                o_err <= 1'b1;

            // The line counter is reused to count pad lines once data lines are done.
            if (state == IDLE && i_start) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (state != PAD && state != PAD_WAIT && state_nxt == PAD) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (xfer || pad_emit) begin
                pix_cnt <= line_end ? '0 : pix_cnt + 1'b1;
                if (line_end)
                    line_cnt <= line_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder on a reduced geometry (16 px x 8 lines, 4 buffers, 2 pad lines).
module tb_pixel_feeder;

    localparam int LW = 16;
    localparam int NL = 8;
    localparam int NB = 4;
    localparam int PL = 2;

    logic       clk = 1'b0;
    logic       i_rst, i_start, i_s_valid, i_intr;
    logic [7:0] i_s_data;
    logic       o_s_ready, o_pixel_data_valid, o_busy, o_done, o_err;
    logic [7:0] o_pixel_data;

    always #5 clk = ~clk;

    pixel_feeder #(
        .LINE_WIDTH (LW),
        .NUM_LINES  (NL),
        .NUM_BUFFERS(NB),
        .PAD_LINES  (PL)
    ) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_s_data          (i_s_data),
        .i_s_valid         (i_s_valid),
        .o_s_ready         (o_s_ready),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .i_intr            (i_intr),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int nvalid   = 0;
    int nzero    = 0;
    int ndone    = 0;

    always @(negedge clk) begin
        if (o_pixel_data_valid) begin
            nvalid++;
            if (o_pixel_data == 8'h00)
                nzero++;
        end
        if (o_done)
            ndone++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(o_s_ready), 0);
        check({tag, "_valid"}, 32'(o_pixel_data_valid), 0);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_err"},   32'(o_err), 0);
        check({tag, "_data"},  32'(o_pixel_data), 0);
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        tick();
        i_intr = 1'b0;
    endtask

    initial begin
        int         n, b_valid, b_zero, b_done;
        int         dl[$];
        logic       xf;
        logic [7:0] d;

        i_rst = 1'b1; i_start = 1'b0; i_s_valid = 1'b0; i_intr = 1'b0; i_s_data = '0;
        tick(); tick();
        check_reset_state("reset");
        i_rst = 1'b0;
        tick();

        // Four buffers, no returns: four lines then stall.
        i_s_valid = 1'b1; i_s_data = 8'h5A; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (80) begin
            i_s_data = 8'($urandom_range(255, 1));
            tick();
        end
        check("stall_px",    32'(nvalid), 64);
        check("stall_ready", 32'(o_s_ready), 0);
        check("stall_busy",  32'(o_busy), 1);

        pulse_intr();
        repeat (40) tick();
        check("one_credit_px",    32'(nvalid), 80);
        check("one_credit_ready", 32'(o_s_ready), 0);

        // Upstream valid on alternate cycles: each accepted pixel must appear one cycle later.
        pulse_intr();
        n = 0;
        for (int k = 0; k < 48; k++) begin
            i_s_valid = k[0];
            i_s_data  = 8'($urandom_range(255, 1));
            xf = o_s_ready && i_s_valid;
            d  = i_s_data;
            tick();
            if (xf) n++;
            check("lat_valid", 32'(o_pixel_data_valid), 32'(xf));
            if (xf)
                check("lat_data", 32'(o_pixel_data), 32'(d));
        end
        check("gap_line_px",    n, 16);
        check("gap_line_ready", 32'(o_s_ready), 0);

        // Buffer freed in the same cycle as the last pixel of a line at one credit.
        i_s_valid = 1'b1;
        pulse_intr();
        n = 0;
        for (int k = 0; k < 40 && n < 16; k++) begin
            i_s_data = 8'($urandom_range(255, 1));
            if (o_s_ready) begin
                n++;
                i_intr = (n == 16);
            end
            tick();
            i_intr = 1'b0;
        end
        check("coincident_px",       n, 16);
        check("coincident_no_stall", 32'(o_s_ready), 1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            i_s_data = 8'($urandom_range(255, 1));
            if (o_s_ready) n++;
            tick();
        end
        check("last_line_px",    n, 16);
        check("last_line_ready", 32'(o_s_ready), 0);

        i_s_valid = 1'b0;
        b_valid = nvalid; b_zero = nzero; b_done = ndone;
        pulse_intr(); pulse_intr(); pulse_intr();
        repeat (60) tick();
        check("pad1_zero_px", 32'(nzero - b_zero), 32);
        check("pad1_all_px",  32'(nvalid - b_valid), 32);
        check("pad1_done",    32'(ndone - b_done), 1);
        check("pad1_busy",    32'(o_busy), 0);
        check("pad1_err",     32'(o_err), 0);

        // Refill to four credits, then a full frame with buffers returned 20 cycles after each line.
        pulse_intr(); pulse_intr(); pulse_intr();
        tick();
        b_valid = nvalid; b_zero = nzero; b_done = ndone;
        i_s_valid = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        dl.delete();
        for (int c = 0; c < 260; c++) begin
            i_s_data = 8'($urandom_range(255, 1));
            i_intr   = 1'b0;
            if (dl.size() > 0 && dl[0] == c) begin
                i_intr = 1'b1;
                void'(dl.pop_front());
            end
            tick();
            if (o_pixel_data_valid) begin
                n++;
                if (n % LW == 0)
                    dl.push_back(c + 20);
            end
        end
        i_intr = 1'b0;
        check("frame_data_px", 32'((nvalid - b_valid) - (nzero - b_zero)), NL * LW);
        check("frame_zero_px", 32'(nzero - b_zero), PL * LW);
        check("frame_done",    32'(ndone - b_done), 1);
        check("frame_busy",    32'(o_busy), 0);
        check("frame_err",     32'(o_err), 0);

        // Extra buffer return while already at full credit.
        pulse_intr();
        tick();
        check("overflow_err",  32'(o_err), 1);
        check("overflow_busy", 32'(o_busy), 0);

        b_valid = nvalid;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (80) tick();
        check("credits_kept_px",    32'(nvalid - b_valid), 64);
        check("credits_kept_ready", 32'(o_s_ready), 0);
        check("err_sticky",         32'(o_err), 1);

        // Reset in the middle of a line.
        pulse_intr();
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            if (o_s_ready) n++;
            tick();
        end
        check("midline_px", n, 10);
        i_rst = 1'b1;
        tick();
        check_reset_state("midreset");
        i_rst = 1'b0;
        tick();

        b_valid = nvalid;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (80) tick();
        check("after_reset_px",    32'(nvalid - b_valid), 64);
        check("after_reset_ready", 32'(o_s_ready), 0);
        check("after_reset_busy",  32'(o_busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 Parameter LINE_WIDTH, default 512, SHALL set pixels per image line.
REQ-002 Parameter NUM_LINES, default 512, SHALL set image lines per frame.
REQ-003 Parameter NUM_BUFFERS, default 4, SHALL set the number of downstream line buffers, which is also the initial and maximum credit count.
REQ-004 Parameter PAD_LINES, default 2, SHALL set the number of all-zero lines appended after each frame to flush the downstream window.
REQ-005 Ports SHALL be:
- i_clk  in  1  sole clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a frame.
- i_s_data  in  8  upstream pixel.
- i_s_valid  in  1  upstream pixel valid.
- o_s_ready  out  1  upstream ready.
- o_pixel_data  out  8  pixel to the line-buffer controller.
- o_pixel_data_valid  out  1  o_pixel_data qualifier.
- i_intr  in  1  one-cycle pulse from the line-buffer controller meaning one line buffer was freed.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame end.
- o_err  out  1  sticky credit-overflow flag.

Function
REQ-006 The FSM SHALL have the states IDLE, SEND, WAIT_CREDIT, PAD, PAD_WAIT and DONE.
REQ-007 In IDLE, i_start SHALL clear the pixel and line counters and enter SEND; i_start in any other state SHALL be ignored.
REQ-008 o_s_ready SHALL be combinational and equal to (state==SEND).
REQ-009 A transfer SHALL occur on a cycle with i_s_valid & o_s_ready; o_pixel_data SHALL be registered from i_s_data and o_pixel_data_valid SHALL be 1 on the following cycle (1-cycle latency); o_pixel_data_valid SHALL be 0 otherwise.
REQ-010 The pixel counter (clog2(LINE_WIDTH) bits) SHALL increment per transfer and wrap to 0 after LINE_WIDTH-1; that transfer SHALL increment the line counter and consume one credit.
REQ-011 At line end in SEND: if the credit count becomes 0, go to WAIT_CREDIT; else if the line counter reaches NUM_LINES, go to PAD (or to DONE when PAD_LINES=0); else stay in SEND.
REQ-012 WAIT_CREDIT SHALL return to SEND (or to PAD if all NUM_LINES lines are sent) on the cycle after the credit count is nonzero.
REQ-013 PAD SHALL emit one zero pixel per cycle with o_pixel_data_valid=1 and the same 1-cycle registration; it SHALL use the same per-line credit accounting, with PAD_WAIT as the wait state.
REQ-014 After PAD_LINES pad lines, the FSM SHALL enter DONE, assert o_done for exactly one cycle, and return to IDLE.
REQ-015 o_busy SHALL be 1 in every state except IDLE.
REQ-016 The credit counter SHALL be clog2(NUM_BUFFERS+1) bits wide and SHALL be set to NUM_BUFFERS only by reset, not by i_start.
REQ-017 Each i_intr SHALL add one credit.
REQ-018 If i_intr and a line-end consume occur in the same cycle, the credit count SHALL be unchanged.
REQ-019 i_intr while credits==NUM_BUFFERS and with no simultaneous consume SHALL be dropped and SHALL set o_err, which stays 1 until reset.
REQ-020 i_intr SHALL be honoured in every state, including IDLE.
REQ-021 Credits SHALL never underflow; no pixel of a new line SHALL be accepted or emitted while the credit count is 0.

Reset
REQ-022 i_rst SHALL apply on any cycle, including mid-line: state=IDLE, counters=0, credits=NUM_BUFFERS, and o_s_ready, o_pixel_data_valid, o_busy, o_done and o_err all 0; o_pixel_data SHALL be 0x00.
REQ-023 No partial-line recovery SHALL occur after reset; the next i_start SHALL begin at pixel 0, line 0.

Verification
REQ-024 Reset, then i_start with i_s_valid held 1 and no i_intr -> exactly 2048 valid pixels, then WAIT_CREDIT with o_s_ready=0.
REQ-025 From that WAIT_CREDIT, one i_intr pulse -> exactly 512 more pixels, then WAIT_CREDIT again.
REQ-026 Upstream valid toggled every other cycle -> the output sequence equals the input sequence with no gaps inserted other than those from upstream, and each pixel appears 1 cycle after its transfer.
REQ-027 i_intr coincident with the line-end transfer at credits=1 -> credits stay 1 and SEND continues without a stall.
REQ-028 Full frame with i_intr returned 20 cycles after each line -> 512x512 data pixels, then 1024 zero pixels, one o_done pulse, then o_busy=0.
REQ-029 i_intr in IDLE with credits=4 -> o_err=1, credits stay 4; i_rst mid-frame at pixel 300 -> all outputs at reset values on the next cycle.
